// File: rtl/montgomery_pkg.sv
// rtl/montgomery_pkg.sv - shared encodings and helpers for the Montgomery domain converter
package montgomery_pkg;

    localparam logic MODE_TO_MONT   = 1'b0;
    localparam logic MODE_FROM_MONT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        OUT
    } state_t;

    // Wide enough to express m_size values above NBITS so they can be rejected.
    function automatic int msize_w(input int nbits);
        return $clog2(nbits) + 3;
    endfunction

endpackage

// File: rtl/mont_r2_step.sv
// rtl/mont_r2_step.sv - one radix-2 Montgomery iteration: add b, add m if odd, halve
module mont_r2_step #(
    parameter int NBITS = 2048
) (
    input  logic [NBITS+1:0] acc,
    input  logic             a_bit,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic [NBITS+1:0] acc_next
);

    logic [NBITS+1:0] t_add;
    logic [NBITS+1:0] t_red;

    // acc < 2m holds between iterations, so t_red < 4m fits in NBITS+2 bits.
    assign t_add    = acc + (a_bit ? {2'b00, b} : '0);
    assign t_red    = t_add + (t_add[0] ? {2'b00, m} : '0);
    assign acc_next = t_red >> 1;

endmodule

// File: rtl/montgomery_domain_conv.sv
// rtl/montgomery_domain_conv.sv - bit-serial converter into and out of the Montgomery domain
module montgomery_domain_conv
    import montgomery_pkg::*;
#(
    parameter int NBITS   = 2048,
    parameter int MSIZE_W = msize_w(NBITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   m,
    input  logic [NBITS-1:0]   r2_red,
    input  logic [MSIZE_W-1:0] m_size,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS-1:0]   y,
    output logic               err,
    output logic               done_irq_p
);

    state_t             state;
    logic [NBITS-1:0]   a_sh;
    logic [NBITS-1:0]   b_r;
    logic [NBITS-1:0]   m_r;
    logic [MSIZE_W-1:0] msize_r;
    logic [MSIZE_W-1:0] cnt;
    logic [NBITS+1:0]   acc;
    logic [NBITS+1:0]   acc_next;
    logic [NBITS+1:0]   acc_red;
    logic               illegal;

    mont_r2_step #(.NBITS(NBITS)) u_step (
        .acc      (acc),
        .a_bit    (a_sh[0]),
        .b        (b_r),
        .m        (m_r),
        .acc_next (acc_next)
    );

    assign illegal = !m[0] || (m_size == '0) || (m_size > MSIZE_W'(NBITS))
                     || ((m >> m_size) != '0);

    assign acc_red = (acc >= {2'b00, m_r}) ? acc - {2'b00, m_r} : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_r        <= '0;
            m_r        <= '0;
            msize_r    <= '0;
            cnt        <= '0;
            acc        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            y          <= '0;
            err        <= 1'b0;
            done_irq_p <= 1'b0;
        end else begin
            done_irq_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        m_r      <= m;
                        b_r      <= (mode == MODE_TO_MONT) ? r2_red : NBITS'(1);
                        msize_r  <= m_size;
                        in_ready <= 1'b0;
                        if (illegal) begin
                            y          <= '0;
                            err        <= 1'b1;
                            out_valid  <= 1'b1;
                            done_irq_p <= 1'b1;
                            state      <= OUT;
                        end else begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + MSIZE_W'(1);
                    if (cnt == msize_r - MSIZE_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    y          <= NBITS'(acc_red);
                    err        <= 1'b0;
                    out_valid  <= 1'b1;
                    done_irq_p <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_domain_conv.sv
// tb/tb_montgomery_domain_conv.sv - self-checking bench for montgomery_domain_conv
module tb_montgomery_domain_conv;
    import montgomery_pkg::*;

    localparam int NB = 64;
    localparam int MW = msize_w(NB);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [NB-1:0] a = '0;
    logic [NB-1:0] m = '0;
    logic [NB-1:0] r2_red = '0;
    logic [MW-1:0] m_size = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NB-1:0] y;
    logic          err;
    logic          done_irq_p;

    int n_tests = 0;
    int n_fail  = 0;

    montgomery_domain_conv #(.NBITS(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .a          (a),
        .m          (m),
        .r2_red     (r2_red),
        .m_size     (m_size),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .err        (err),
        .done_irq_p (done_irq_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          md;
        logic [NB-1:0] av;
        logic [NB-1:0] mv;
        logic [NB-1:0] rv;
        logic [MW-1:0] ms;
        logic [NB-1:0] exp_y;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a * 2^k mod m (inv=0) or a * 2^-k mod m (inv=1) by modular doubling / halving
    function automatic logic [NB-1:0] ref_scale(input logic [NB-1:0] av, input logic [NB-1:0] mv,
                                                 input int k, input bit inv);
        logic [NB:0] x;
        x = {1'b0, av};
        for (int i = 0; i < k; i++) begin
            if (!inv) begin
                x = x << 1;
                if (x >= {1'b0, mv}) x = x - {1'b0, mv};
            end else begin
                if (x[0]) x = x + {1'b0, mv};
                x = x >> 1;
            end
        end
        return x[NB-1:0];
    endfunction

    task automatic run_txn(input logic md, input logic [NB-1:0] av, input logic [NB-1:0] mv,
                           input logic [NB-1:0] rv, input logic [MW-1:0] ms,
                           output logic [NB-1:0] yv, output logic ev, output int lat,
                           output int irqs, output logic ov_after);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        mode = md; a = av; m = mv; r2_red = rv; m_size = ms; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom}; m = {$urandom, $urandom}; r2_red = {$urandom, $urandom};
        mode = ~md; m_size = MW'($urandom);
        lat = 1;
        irqs = 0;
        while (!out_valid && lat < 300) begin
            irqs += int'(done_irq_p);
            @(negedge clk);
            lat++;
        end
        irqs += int'(done_irq_p);
        yv = y;
        ev = err;
        @(negedge clk);
        irqs += int'(done_irq_p);
        ov_after = out_valid;
    endtask

    task automatic run_check(input string name, input vec_t v);
        logic [NB-1:0] yv;
        logic ev, ova;
        int lat, irqs;
        run_txn(v.md, v.av, v.mv, v.rv, v.ms, yv, ev, lat, irqs, ova);
        check({name, ".y"}, yv, v.exp_y);
        check({name, ".err"}, NB'(ev), NB'(v.exp_err));
        check({name, ".lat"}, NB'(lat), NB'(v.exp_lat));
        check({name, ".irq"}, NB'(irqs), NB'(1));
        check({name, ".drop"}, NB'(ova), NB'(0));
    endtask

    vec_t vecs[12];

    initial begin
        logic [NB-1:0] yv, mm, av, r2;
        logic ev, ova, md;
        int lat, irqs, k, cnt;

        vecs[0]  = '{MODE_TO_MONT,   5,  13, 9, 4,  2, 1'b0, 6};
        vecs[1]  = '{MODE_FROM_MONT, 2,  13, 9, 4,  5, 1'b0, 6};
        vecs[2]  = '{MODE_FROM_MONT, 12, 13, 9, 4,  4, 1'b0, 6};
        vecs[3]  = '{MODE_TO_MONT,   5,  13, 9, 4,  2, 1'b0, 6};
        vecs[4]  = '{MODE_FROM_MONT, 2,  13, 9, 4,  5, 1'b0, 6};
        vecs[5]  = '{MODE_TO_MONT,   5,  12, 9, 4,  0, 1'b1, 1};
        vecs[6]  = '{MODE_TO_MONT,   5,  13, 9, 0,  0, 1'b1, 1};
        vecs[7]  = '{MODE_TO_MONT,   5,  13, 9, 3,  0, 1'b1, 1};
        vecs[8]  = '{MODE_TO_MONT,   5,  13, 9, 65, 0, 1'b1, 1};
        vecs[9]  = '{MODE_TO_MONT,   0,  13, 9, 4,  0, 1'b0, 6};
        vecs[10] = '{MODE_FROM_MONT, 0,  1,  0, 1,  0, 1'b0, 3};
        vecs[11] = '{MODE_TO_MONT,   5,  64'hFFFF_FFFF_FFFF_FFFF, 1, 64, 5, 1'b0, 66};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready", NB'(in_ready), NB'(1));
        check("reset.out_valid", NB'(out_valid), NB'(0));
        check("reset.y", y, '0);
        check("reset.err", NB'(err), NB'(0));
        check("reset.irq", NB'(done_irq_p), NB'(0));

        for (int i = 0; i < 12; i++) run_check($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held while out_ready is low, requests ignored
        out_ready = 1'b0;
        mode = MODE_TO_MONT; a = 5; m = 13; r2_red = 9; m_size = 4; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("bp.rise", NB'(out_valid), NB'(1));
        irqs = 0;
        for (int c = 0; c < 5; c++) begin
            irqs += int'(done_irq_p);
            check("bp.y", y, 2);
            check("bp.valid", NB'(out_valid), NB'(1));
            check("bp.in_ready", NB'(in_ready), NB'(0));
            in_valid = 1'b1; a = 7; mode = MODE_FROM_MONT;
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("bp.irq", NB'(irqs), NB'(1));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.drop", NB'(out_valid), NB'(0));
        check("bp.in_ready_back", NB'(in_ready), NB'(1));
        check("bp.y_kept", y, 2);

        // Reset in the middle of ITER aborts with no output
        mode = MODE_TO_MONT; a = 5; m = 13; r2_red = 9; m_size = 4; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.in_ready", NB'(in_ready), NB'(1));
        check("rst.out_valid", NB'(out_valid), NB'(0));
        check("rst.y", y, '0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cnt += int'(done_irq_p) + int'(out_valid);
            @(negedge clk);
        end
        check("rst.quiet", NB'(cnt), NB'(0));
        run_check("rst.after", vecs[0]);

        // Width sweep with m = 2^61 - 1
        mm = (64'd1 << 61) - 1;
        r2 = ref_scale(1, mm, 122, 1'b0);
        for (int i = 0; i < 200; i++) begin
            md = 1'($urandom);
            av = {$urandom, $urandom} % mm;
            run_txn(md, av, mm, r2, 61, yv, ev, lat, irqs, ova);
            check("sweep.y", yv, ref_scale(av, mm, 61, md));
            check("sweep.lt_m", NB'(yv < mm), NB'(1));
            check("sweep.lat", NB'(lat), NB'(63));
            check("sweep.err", NB'(ev), NB'(0));
        end

        // Random odd moduli of random width
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(2, 64);
            mm = {$urandom, $urandom};
            if (k < 64) mm = mm & ((64'd1 << k) - 1);
            mm[k-1] = 1'b1;
            mm[0] = 1'b1;
            av = {$urandom, $urandom} % mm;
            md = 1'($urandom);
            r2 = ref_scale(1, mm, 2 * k, 1'b0);
            run_txn(md, av, mm, r2, MW'(k), yv, ev, lat, irqs, ova);
            check("rnd.y", yv, ref_scale(av, mm, k, md));
            check("rnd.lat", NB'(lat), NB'(k + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/montgomery_domain_conv.md
Name: montgomery_domain_conv

Overview:
Self-contained, bit-serial, radix-2 Montgomery domain converter with a valid/ready handshake on both sides.
- mode TO_MONT: y = a·R mod m, computed as MontMul(a, r2_red) with r2_red = R² mod m.
- mode FROM_MONT: y = a·R⁻¹ mod m, computed as MontMul(a, 1).
- R = 2^m_size, where m_size is a per-transaction runtime input.
- Sits between the key/operand store and the modexp datapath. It replaces the fixed-direction, wrapper-style converter with one block that handles both directions, applies backpressure and flags errors.

Parameters:
- NBITS, 2048, maximum modulus/operand width in bits.
- MSIZE_W, $clog2(NBITS)+3, width of the m_size input.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request.
- mode, input, 1, 0 = TO_MONT, 1 = FROM_MONT; sampled at accept.
- a, input, NBITS, operand; caller guarantees a < m.
- m, input, NBITS, odd modulus.
- r2_red, input, NBITS, R² mod m; used only in TO_MONT.
- m_size, input, MSIZE_W, number of significant modulus bits; R = 2^m_size.
- out_valid, output, 1, result valid; held until out_ready.
- out_ready, input, 1, consumer accepts the result.
- y, output, NBITS, result; zero-extended above m_size.
- err, output, 1, qualifies y when out_valid is high: illegal request, y = 0.
- done_irq_p, output, 1, one-cycle pulse in the cycle out_valid rises.

Behaviour:
- Reset values: in_ready = 1, out_valid = 0, y = 0, err = 0, done_irq_p = 0, FSM = IDLE, internal registers cleared.
- Reset mid-operation aborts the transaction with no output. Reset has priority over all other events.
- Accept: an edge where in_valid && in_ready. On accept the block captures:
  - a, m and mode;
  - b = (mode == TO_MONT) ? r2_red : 1;
  - m_size.
- Legality check at accept. The request is an error if any of these holds:
  - m[0] == 0;
  - m_size == 0;
  - m_size > NBITS;
  - (m >> m_size) != 0.
- FSM states: IDLE, ITER, FIX, OUT.
  - IDLE: in_ready = 1. On a legal accept go to ITER with acc = 0 and cnt = 0. On an illegal accept go to OUT with err = 1 and y = 0.
  - ITER: one iteration per cycle, acc width NBITS+2:
    1. t = acc + (a[cnt] ? b : 0)
    2. t = t + (t[0] ? m : 0)
    3. acc = t >> 1
    4. cnt++
    - After the iteration with cnt == m_size-1, go to FIX.
  - FIX: y = (acc >= m) ? acc - m : acc. One conditional subtraction is sufficient because a, b < m. Set err = 0 and go to OUT.
  - OUT: out_valid = 1, with y and err held stable. Stay in OUT while out_ready == 0. When out_ready == 1, go to IDLE with out_valid = 0 on the following cycle.
- in_ready is 1 only in IDLE. There is no pipelining: one transaction is in flight at a time.
- Latency, measured from the accept edge to the first cycle with out_valid = 1:
  - legal request: m_size + 2 cycles;
  - error: 1 cycle.
- done_irq_p is high for exactly the first cycle of each OUT visit, independent of out_ready.
- Simultaneous out_ready and in_valid in OUT: the result is consumed, and the new request is not accepted until the next IDLE cycle (in_ready is 0 in OUT).
- Changes on the inputs after accept have no effect on the transaction in flight.
- Degenerate inputs: a = 0 gives y = 0 in either mode. m = 1 with m_size = 1 gives y = 0.

Decomposition:
- Package montgomery_pkg holds:
  - mode encodings MODE_TO_MONT = 1'b0 and MODE_FROM_MONT = 1'b1;
  - the FSM state enum (IDLE, ITER, FIX, OUT);
  - the MSIZE_W derivation function.
- One natural sub-module, mont_r2_step: the combinational single-iteration add/add/shift datapath, parametrised by NBITS.
- The FSM, counter, handshake and final subtraction stay in montgomery_domain_conv.

Test Plan:
All scenarios use NBITS = 8, m = 13, m_size = 4 (R = 16, r2_red = 9) unless noted.
- TO_MONT, a = 5, out_ready = 1 → y = 2, err = 0; out_valid rises 6 cycles after accept; done_irq_p high for 1 cycle.
- FROM_MONT, a = 2 → y = 5. FROM_MONT, a = 12 → y = 4. Back-to-back round trip: TO_MONT 5 → 2, then FROM_MONT 2 → 5.
- Illegal requests, each → err = 1, y = 0, out_valid 1 cycle after accept:
  - m = 12 (even);
  - m_size = 0;
  - m = 13 with m_size = 3 (modulus exceeds m_size).
- Backpressure: TO_MONT a = 5 with out_ready held 0 for 5 cycles →
  - y = 2 and out_valid stay stable throughout;
  - in_ready stays 0 and in_valid pulses are ignored;
  - done_irq_p pulses once;
  - out_ready = 1 → out_valid drops next cycle and in_ready returns to 1.
- Reset: assert rst 2 cycles into ITER → next cycle in_ready = 1, out_valid = 0, y = 0, and no done_irq_p. A following TO_MONT a = 5 then returns 2.
- Width sweep: NBITS = 64, m = 2^61 - 1, m_size = 61. Run 200 random a < m in both modes and check against a reference model (Python bigint).
  - y < m for every result.
  - Latency is 63 cycles for every result.
